gate_array_pipe: RTL

- Parametrised, pipelined successor to the team's two-input gate block.
- Applies one of eight bitwise logic operations, selected per transaction, to two WIDTH-bit operands.
- Registers the result together with status flags, behind a valid/ready handshake on both sides.
- Used as a generic registered logic stage between datapath blocks that apply backpressure.

---
 rtl/gate_array_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gate_array_pipe.sv
// Two-stage registered bitwise logic unit (8 selectable ops) with valid/ready on both sides.
// Define GATES_POPCOUNT_EN to add the registered out_cnt popcount output.
module gate_array_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic [2:0]       out_op
`ifdef GATES_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_cnt
`endif
);

  function automatic logic [WIDTH-1:0] gate_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~a;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      3'd7: r = b;
    endcase
    return r;
  endfunction

`ifdef GATES_POPCOUNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction
`endif

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic             s2_zero_q, s2_ones_q, s2_par_q;
  logic [2:0]       s2_op_q;

  logic             s2_adv, s1_adv, accept;
  logic [WIDTH-1:0] res_d;
  logic             zero_d, ones_d, par_d;

  // Handshake: in_ready depends only on pipeline state and out_ready
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // ---- Stage S1: operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q  <= in_a;
      s1_b_q  <= in_b;
      s1_op_q <= in_op;
    end
  end

  // Flags come from the S2-bound result so they register alongside it
  assign res_d  = gate_eval(s1_a_q, s1_b_q, s1_op_q);
  assign zero_d = ~|res_d;
  assign ones_d = &res_d;
  assign par_d  = ^res_d;

  // ---- Stage S2: result, flags and op register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b1;
      s2_ones_q  <= 1'b0;
      s2_par_q   <= 1'b0;
      s2_op_q    <= 3'd0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q    <= res_d;
        s2_zero_q <= zero_d;
        s2_ones_q <= ones_d;
        s2_par_q  <= par_d;
        s2_op_q   <= s1_op_q;
      end
    end
  end

`ifdef GATES_POPCOUNT_EN
  logic [CNT_W-1:0] s2_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_cnt_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      s2_cnt_q <= popcnt(res_d);
    end
  end

  assign out_cnt = s2_cnt_q;
`endif

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_zero  = s2_zero_q;
  assign out_ones  = s2_ones_q;
  assign out_par   = s2_par_q;
  assign out_op    = s2_op_q;

endmodule
